// File: rtl/interrupt_controller.sv
// Interrupt sequencer: drains the pipeline, pushes return PC and flags, fetches the vector, redirects fetch.
// Minimum latency: edge to pc_load is 9 cycles; DRAIN waits while mem_busy is high.
module interrupt_controller #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] VECTOR_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_signal,
  input  logic [31:0] pc_next,
  input  logic        pc_redirect,
  input  logic [31:0] pc_redirect_value,
  input  logic [2:0]  flags,
  input  logic        mem_busy,
  input  logic [15:0] vec_data,
  output logic        stall_fetch,
  output logic        flush_dec,
  output logic        mem_grant,
  output logic        mem_push,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        int_active
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, RD_HI, RD_LO, LOAD
  } state_t;

  localparam int          CW        = $clog2(DRAIN_CYCLES + 2);
  localparam logic [CW-1:0] DRAIN_MAX = CW'(DRAIN_CYCLES);
  localparam logic [15:0] VEC_LO    = VECTOR_ADDR + 16'd1;

  state_t        state;
  state_t        state_nxt;
  logic          irq_prev;
  logic          armed;
  logic          pending;
  logic [CW-1:0] cnt;
  logic [31:0]   ret_pc;
  logic [31:0]   ret_pc_nxt;
  logic [2:0]    flags_q;
  logic [15:0]   vec_hi;

  logic          irq_edge;
  logic          drain_done;
  logic          push_nxt;
  logic          read_nxt;
  logic [15:0]   wdata_nxt;
  logic [15:0]   addr_nxt;

  // armed stays low for the first cycle after reset so a level held through reset is not an edge
  assign irq_edge   = armed & interrupt_signal & ~irq_prev;
  assign drain_done = (cnt >= DRAIN_MAX) & ~mem_busy;

  always_comb begin
    state_nxt  = state;
    ret_pc_nxt = ret_pc;
    case (state)
      IDLE: begin
        if (irq_edge || pending) begin
          state_nxt  = DRAIN;
          ret_pc_nxt = pc_next;
        end
      end
      DRAIN: begin
        if (pc_redirect) ret_pc_nxt = pc_redirect_value;
        if (drain_done) state_nxt = PUSH_HI;
      end
      PUSH_HI: state_nxt = PUSH_LO;
      PUSH_LO: state_nxt = PUSH_FL;
      PUSH_FL: state_nxt = RD_HI;
      RD_HI:   state_nxt = RD_LO;
      RD_LO:   state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the state being entered, so the outputs come straight from flops
  always_comb begin
    push_nxt  = 1'b0;
    read_nxt  = 1'b0;
    wdata_nxt = 16'h0000;
    addr_nxt  = 16'h0000;
    case (state_nxt)
      PUSH_HI: begin push_nxt = 1'b1; wdata_nxt = ret_pc_nxt[31:16];    end
      PUSH_LO: begin push_nxt = 1'b1; wdata_nxt = ret_pc_nxt[15:0];     end
      PUSH_FL: begin push_nxt = 1'b1; wdata_nxt = {13'b0, flags_q};     end
      RD_HI:   begin read_nxt = 1'b1; addr_nxt  = VECTOR_ADDR;          end
      RD_LO:   begin read_nxt = 1'b1; addr_nxt  = VEC_LO;               end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_prev    <= 1'b0;
      armed       <= 1'b0;
      pending     <= 1'b0;
      cnt         <= '0;
      ret_pc      <= 32'h0;
      flags_q     <= 3'b0;
      vec_hi      <= 16'h0;
      stall_fetch <= 1'b0;
      flush_dec   <= 1'b0;
      mem_grant   <= 1'b0;
      mem_push    <= 1'b0;
      mem_read    <= 1'b0;
      mem_addr    <= 16'h0;
      mem_wdata   <= 16'h0;
      pc_load     <= 1'b0;
      int_active  <= 1'b0;
    end else begin
      irq_prev <= interrupt_signal;
      armed    <= 1'b1;
      state    <= state_nxt;
      ret_pc   <= ret_pc_nxt;

      if (state == IDLE && state_nxt == DRAIN)
        pending <= 1'b0;
      else if (state != IDLE && irq_edge)
        pending <= 1'b1;

      if (state_nxt == DRAIN) begin
        if (state != DRAIN)
          cnt <= CW'(1);
        else if (cnt < DRAIN_MAX)
          cnt <= cnt + CW'(1);
      end

      if (state == DRAIN && state_nxt == PUSH_HI)
        flags_q <= flags;
      if (state == RD_LO)
        vec_hi <= vec_data;

      stall_fetch <= (state_nxt != IDLE);
      flush_dec   <= (state_nxt != IDLE);
      int_active  <= (state_nxt != IDLE);
      mem_grant   <= push_nxt | read_nxt;
      mem_push    <= push_nxt;
      mem_read    <= read_nxt;
      mem_wdata   <= wdata_nxt;
      mem_addr    <= addr_nxt;
      pc_load     <= (state_nxt == LOAD);
    end
  end

  // Low vector word arrives on vec_data in the LOAD cycle itself
  assign pc_load_value = pc_load ? {vec_hi, vec_data} : 32'h0;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expected memory/pc_load events are queued with their cycle.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt_signal;
  logic [31:0] pc_next;
  logic        pc_redirect;
  logic [31:0] pc_redirect_value;
  logic [2:0]  flags;
  logic        mem_busy;
  logic [15:0] vec_data;
  logic        stall_fetch, flush_dec, mem_grant, mem_push, mem_read;
  logic [15:0] mem_addr, mem_wdata;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        int_active;

  interrupt_controller dut (
    .clk(clk), .rst(rst), .interrupt_signal(interrupt_signal), .pc_next(pc_next),
    .pc_redirect(pc_redirect), .pc_redirect_value(pc_redirect_value), .flags(flags),
    .mem_busy(mem_busy), .vec_data(vec_data), .stall_fetch(stall_fetch), .flush_dec(flush_dec),
    .mem_grant(mem_grant), .mem_push(mem_push), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pc_load(pc_load), .pc_load_value(pc_load_value), .int_active(int_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0 push, 1 read, 2 pc_load
    logic [31:0] val;
  } ev_t;

  ev_t         sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          mon_en = 1'b0;
  logic [15:0] tb_mem [0:3];

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: read data valid the cycle after mem_read
  always @(posedge clk) vec_data <= (mem_read && mem_addr < 16'd4) ? tb_mem[mem_addr[1:0]] : 16'h0;

  task automatic push_ev(input int c, input int k, input logic [31:0] v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  // Expected events of one service whose edge is at cycle t, delayed by s, first n events only
  task automatic expect_seq(input int t, input int s, input logic [31:0] rpc, input logic [2:0] fl, input int n);
    ev_t seq [6];
    seq[0] = '{t + 4 + s, 0, {16'h0, rpc[31:16]}};
    seq[1] = '{t + 5 + s, 0, {16'h0, rpc[15:0]}};
    seq[2] = '{t + 6 + s, 0, {29'h0, fl}};
    seq[3] = '{t + 7 + s, 1, 32'h0};
    seq[4] = '{t + 8 + s, 1, 32'h1};
    seq[5] = '{t + 9 + s, 2, {tb_mem[0], tb_mem[1]}};
    for (int i = 0; i < n; i++) push_ev(seq[i].cyc, seq[i].kind, seq[i].val);
  endtask

  // Monitor: compares every observed memory/pc_load event with the scoreboard head
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL missed_event cyc=%0d kind=%0d val=%h not seen", sb[0].cyc, sb[0].kind, sb[0].val);
        void'(sb.pop_front());
      end
      if (mem_push || mem_read || pc_load) begin
        int          ok;
        int          k;
        logic [31:0] v;
        ev_t         e;
        k = pc_load ? 2 : (mem_read ? 1 : 0);
        v = pc_load ? pc_load_value : (mem_read ? {16'h0, mem_addr} : {16'h0, mem_wdata});
        ok = (32'(mem_push) + 32'(mem_read) + 32'(pc_load)) == 1;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event cyc=%0d kind=%0d val=%h", cyc, k, v);
        end else begin
          e = sb.pop_front();
          if (!ok || e.cyc != cyc || e.kind != k || v !== e.val) begin
            bad++;
            $display("FAIL event cyc=%0d kind=%0d val=%h required cyc=%0d kind=%0d val=%h",
                     cyc, k, v, e.cyc, e.kind, e.val);
          end
        end
        total++;
        if (mem_grant !== (mem_push | mem_read)) begin
          bad++;
          $display("FAIL mem_grant cyc=%0d got=%b required=%b", cyc, mem_grant, mem_push | mem_read);
        end
      end else begin
        total++;
        if (pc_load_value !== 32'h0 || mem_wdata !== 16'h0 || mem_addr !== 16'h0 || mem_grant !== 1'b0) begin
          bad++;
          $display("FAIL idle_outputs cyc=%0d pcv=%h wdata=%h addr=%h grant=%b required all 0",
                   cyc, pc_load_value, mem_wdata, mem_addr, mem_grant);
        end
      end
    end
  end

  // Advance to the negative edge of cycle c
  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_sb_left got=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; interrupt_signal = 1'b1; pc_next = 32'h0; pc_redirect = 1'b0;
    pc_redirect_value = 32'h0; flags = 3'b0; mem_busy = 1'b0;
    repeat (3) step();
    @(negedge clk);
    mon_en = 1'b1;
    total++;
    if ({stall_fetch, flush_dec, mem_grant, mem_push, mem_read, pc_load, int_active} !== 7'b0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 || pc_load_value !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs stall=%b act=%b addr=%h wdata=%h pcv=%h required all 0",
               stall_fetch, int_active, mem_addr, mem_wdata, pc_load_value);
    end
    rst = 1'b0;
    at(cyc + 6);
    total++;
    if (int_active !== 1'b0 || stall_fetch !== 1'b0) begin
      bad++;
      $display("FAIL held_level_not_edge act=%b stall=%b required 0 0", int_active, stall_fetch);
    end
    interrupt_signal = 1'b0;
    at(cyc + 2);
    check_drained("reset");
  endtask

  task automatic test_basic();
    int t;
    tb_mem[0] = 16'h0000; tb_mem[1] = 16'h0200;
    pc_next = 32'h0000_0040; flags = 3'b101; mem_busy = 1'b0;
    step();
    t = cyc;
    interrupt_signal = 1'b1;
    expect_seq(t, 0, 32'h0000_0040, 3'b101, 6);
    at(t);
    total++;
    if (int_active !== 1'b0) begin
      bad++; $display("FAIL basic_idle_at_t got=%b required=0", int_active);
    end
    at(t + 1);
    total++;
    if ({stall_fetch, flush_dec, int_active, mem_grant} !== 4'b1110) begin
      bad++;
      $display("FAIL basic_drain_outputs got=%b required=1110", {stall_fetch, flush_dec, int_active, mem_grant});
    end
    interrupt_signal = 1'b0;
    at(t + 10);
    total++;
    if ({stall_fetch, flush_dec, int_active} !== 3'b000) begin
      bad++; $display("FAIL basic_idle_t10 got=%b required=000", {stall_fetch, flush_dec, int_active});
    end
    at(t + 13);
    check_drained("basic");
  endtask

  task automatic test_mem_busy();
    int t;
    tb_mem[0] = 16'hABCD; tb_mem[1] = 16'h1357;
    pc_next = 32'hDEAD_BEEF; flags = 3'b110; mem_busy = 1'b1;
    step();
    t = cyc;
    interrupt_signal = 1'b1;
    expect_seq(t, 3, 32'hDEAD_BEEF, 3'b110, 6);
    at(t + 2);
    interrupt_signal = 1'b0;
    at(t + 6);
    total++;
    if (stall_fetch !== 1'b1 || mem_push !== 1'b0) begin
      bad++; $display("FAIL busy_drain_t6 stall=%b push=%b required 1 0", stall_fetch, mem_push);
    end
    mem_busy = 1'b0;
    at(t + 12);
    total++;
    if (int_active !== 1'b1) begin
      bad++; $display("FAIL busy_active_t12 got=%b required=1", int_active);
    end
    at(t + 13);
    total++;
    if (int_active !== 1'b0) begin
      bad++; $display("FAIL busy_idle_t13 got=%b required=0", int_active);
    end
    at(t + 15);
    check_drained("mem_busy");
  endtask

  task automatic test_redirect();
    int t;
    tb_mem[0] = 16'h0001; tb_mem[1] = 16'h8000;
    pc_next = 32'h0000_0040; flags = 3'b010;
    step();
    t = cyc;
    interrupt_signal = 1'b1;
    expect_seq(t, 0, 32'h0000_1234, 3'b010, 6);
    at(t + 2);
    pc_redirect = 1'b1; pc_redirect_value = 32'h0000_1234;
    at(t + 3);
    pc_redirect = 1'b0; pc_redirect_value = 32'hFFFF_FFFF;
    interrupt_signal = 1'b0;
    at(t + 13);
    check_drained("redirect");
  endtask

  task automatic test_back_to_back();
    int t;
    tb_mem[0] = 16'h0000; tb_mem[1] = 16'h0200;
    pc_next = 32'h0000_0040; flags = 3'b101;
    step();
    t = cyc;
    interrupt_signal = 1'b1;
    expect_seq(t, 0, 32'h0000_0040, 3'b101, 6);
    expect_seq(t + 10, 0, 32'h0000_0080, 3'b011, 6);
    at(t + 1);
    pc_next = 32'h0000_0080;
    at(t + 2);
    interrupt_signal = 1'b0;
    at(t + 4);
    flags = 3'b011;
    at(t + 5);
    interrupt_signal = 1'b1;
    at(t + 10);
    total++;
    if (int_active !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_t10 got=%b required=0", int_active);
    end
    at(t + 11);
    total++;
    if (int_active !== 1'b1 || stall_fetch !== 1'b1) begin
      bad++; $display("FAIL b2b_drain_t11 act=%b stall=%b required 1 1", int_active, stall_fetch);
    end
    interrupt_signal = 1'b0;
    at(t + 20);
    total++;
    if (int_active !== 1'b0) begin
      bad++; $display("FAIL b2b_idle_t20 got=%b required=0", int_active);
    end
    at(t + 23);
    check_drained("back_to_back");
  endtask

  task automatic test_reset_mid();
    int t;
    tb_mem[0] = 16'h0000; tb_mem[1] = 16'h0300;
    pc_next = 32'h0055_AA00; flags = 3'b111;
    step();
    t = cyc;
    interrupt_signal = 1'b1;
    expect_seq(t, 0, 32'h0055_AA00, 3'b111, 4);
    at(t + 7);
    rst = 1'b1;
    at(t + 8);
    rst = 1'b0;
    total++;
    if ({stall_fetch, flush_dec, mem_grant, mem_push, mem_read, pc_load, int_active} !== 7'b0 ||
        mem_addr !== 16'h0 || mem_wdata !== 16'h0 || pc_load_value !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid_outputs stall=%b read=%b act=%b addr=%h pcv=%h required all 0",
               stall_fetch, mem_read, int_active, mem_addr, pc_load_value);
    end
    at(t + 22);
    total++;
    if (int_active !== 1'b0) begin
      bad++; $display("FAIL reset_mid_no_service got=%b required=0", int_active);
    end
    interrupt_signal = 1'b0;
    at(t + 24);
    check_drained("reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_mem_busy();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL provide parameter DRAIN_CYCLES, default 3, the minimum number of cycles spent draining the pipeline.
REQ-002 SHALL provide parameter VECTOR_ADDR, default 16'h0000, the data-memory address of the interrupt vector's high word; the low word is at VECTOR_ADDR+1.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 interrupt_signal  in  1  external interrupt request; rising edge is the event.
REQ-006 pc_next  in  32  address of the next instruction fetch would execute.
REQ-007 pc_redirect  in  1  taken jump/call/ret resolved in the pipeline this cycle.
REQ-008 pc_redirect_value  in  32  redirect target, valid with pc_redirect.
REQ-009 flags  in  3  current flag register value.
REQ-010 mem_busy  in  1  memory stage is executing a pipeline memory, push or pop operation.
REQ-011 vec_data  in  16  data-memory read data, valid the cycle after mem_read.
REQ-012 stall_fetch  out  1  hold PC and the fetch/decode register.
REQ-013 flush_dec  out  1  replace the decode instruction with a NOP.
REQ-014 mem_grant  out  1  controller owns the data-memory port this cycle.
REQ-015 mem_push  out  1  push mem_wdata onto the stack (SP handled by the memory stage).
REQ-016 mem_read  out  1  read data memory at mem_addr.
REQ-017 mem_addr  out  16  read address; 0 when mem_read=0.
REQ-018 mem_wdata  out  16  push data; 0 when mem_push=0.
REQ-019 pc_load  out  1  fetch loads pc_load_value, overriding stall_fetch.
REQ-020 pc_load_value  out  32  interrupt handler address.
REQ-021 int_active  out  1  high in every state except IDLE.

Function
REQ-022 SHALL implement the states IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, RD_HI, RD_LO and LOAD, one cycle each except DRAIN.
REQ-023 SHALL detect a rising edge by comparing interrupt_signal with its registered previous value.
REQ-024 In IDLE, a rising edge in cycle t SHALL move to DRAIN at t+1 and capture return_pc=pc_next.
REQ-025 In DRAIN, a cycle counter SHALL start at 1; the state SHALL exit to PUSH_HI when count>=DRAIN_CYCLES and mem_busy=0, otherwise remain; flags SHALL be captured in the exit cycle.
REQ-026 pc_redirect=1 during DRAIN SHALL overwrite return_pc with pc_redirect_value, including in the exit cycle.
REQ-027 PUSH_HI/PUSH_LO/PUSH_FL SHALL assert mem_push with mem_wdata = return_pc[31:16], return_pc[15:0], {13'b0, captured flags} respectively.
REQ-028 RD_HI SHALL assert mem_read with mem_addr=VECTOR_ADDR; RD_LO SHALL assert mem_read with mem_addr=VECTOR_ADDR+1 and capture vec_data as the high word.
REQ-029 LOAD SHALL assert pc_load for exactly one cycle with pc_load_value={high word, vec_data}, then return to IDLE.
REQ-030 stall_fetch and flush_dec SHALL be 1 in all non-IDLE states; mem_grant SHALL be 1 only in PUSH_*, RD_* states.
REQ-031 A rising edge while not IDLE SHALL set a single pending bit (further edges are merged); on LOAD->IDLE with pending set, the next cycle SHALL enter DRAIN, clear pending, and capture return_pc=pc_next.
REQ-032 Minimum latency SHALL be: edge at t, DRAIN t+1..t+3, pushes t+4..t+6, reads t+7..t+8, pc_load at t+9, IDLE at t+10.
REQ-033 pc_load_value SHALL be 0 whenever pc_load=0.

Reset
REQ-034 rst=1 SHALL force IDLE, clear pending, counter, captured values and the edge-detect register, and drive all outputs to 0 in the next cycle, including mid-sequence.
REQ-035 An interrupt_signal held high through reset release SHALL NOT be taken as an edge.

Verification
REQ-036 Edge at t, mem_busy=0, pc_next=32'h0000_0040, flags=3'b101, mem[0]=16'h0000, mem[1]=16'h0200 -> pushes 0000, 0040, 0005 at t+4..t+6; pc_load=1 with 32'h0000_0200 at t+9.
REQ-037 mem_busy=1 through t+5 -> DRAIN holds until t+6, and every later event shifts by +3 cycles.
REQ-038 pc_redirect=1 with 32'h0000_1234 at t+2 -> pushed words are 0000, 1234.
REQ-039 Second edge at t+5 -> first sequence completes, IDLE at t+10, DRAIN at t+11, second pc_load at t+19.
REQ-040 rst=1 at t+7 -> all outputs 0 at t+8, no pc_load, and no service without a new edge.
